// File: rtl/tc_txn_buffer.sv
// ---------------------------------------------------------------------------
// tc_txn_buffer
//
// Transaction-bus target for the tc bus master. Requests are queued in order
// in a small circular FIFO. The address phase is acknowledged whenever the
// queue has room. Each queued transaction is then serviced against an
// internal word array after a fixed number of cycles at the queue head.
//
// Ports
//   clk_bus   in   bus clock, rising edge
//   rst       in   asynchronous, active-high reset
//   tc_req    in   request valid
//   tc_rnw    in   1 = read, 0 = write
//   tc_addr   in   word address (TC_AWIDTH)
//   tc_wdata  in   write data (TC_DWIDTH)
//   tc_aack   out  address acknowledge (queue has room); accept = req & aack
//   tc_rack   out  read complete, one-cycle pulse
//   tc_wack   out  write complete, one-cycle pulse
//   tc_rdata  out  read data, valid with tc_rack, otherwise holds last value
// ---------------------------------------------------------------------------
module tc_txn_buffer #(
    parameter int TC_AWIDTH = 8,
    parameter int TC_DWIDTH = 8,
    parameter int DEPTH     = 4,
    parameter int SVC_LAT   = 2
) (
    input  logic                 clk_bus,
    input  logic                 rst,
    input  logic                 tc_req,
    input  logic                 tc_rnw,
    input  logic [TC_AWIDTH-1:0] tc_addr,
    input  logic [TC_DWIDTH-1:0] tc_wdata,
    output logic                 tc_aack,
    output logic                 tc_rack,
    output logic                 tc_wack,
    output logic [TC_DWIDTH-1:0] tc_rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int WORDS = 1 << TC_AWIDTH;

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    // The timer reads 0 in the first cycle an entry sits at the head, so the
    // SVC_LAT-th head cycle is the one where it reads SVC_LAT-1. This gives
    // r_k = max(t_k, r_{k-1}) + SVC_LAT both for an entry arriving in an
    // empty queue and for one promoted right after a pop.
    localparam logic [3:0]       FIRE_AT  = 4'(SVC_LAT - 1);

    // Pending queue storage (no reset needed: occupancy qualifies it)
    logic                 q_rnw_q   [DEPTH];
    logic [TC_AWIDTH-1:0] q_addr_q  [DEPTH];
    logic [TC_DWIDTH-1:0] q_wdata_q [DEPTH];

    // Target word array
    logic [TC_DWIDTH-1:0] mem_q [WORDS];

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]     occ_q,    occ_d;
    logic [3:0]           timer_q,  timer_d;
    logic [TC_DWIDTH-1:0] rdata_hold_q, rdata_hold_d;

    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 head_rnw;
    logic [TC_AWIDTH-1:0] head_addr;
    logic [TC_DWIDTH-1:0] head_wdata;
    logic [TC_DWIDTH-1:0] head_word;

    // ---------------------------------------------------------------------
    // Handshake and completion decode (registered state only)
    // ---------------------------------------------------------------------
    assign empty      = (occ_q == '0);
    assign tc_aack    = !rst && (occ_q < OCC_FULL);
    assign push       = tc_req && tc_aack;
    assign pop        = !empty && (timer_q == FIRE_AT);

    assign head_rnw   = q_rnw_q[rd_ptr_q];
    assign head_addr  = q_addr_q[rd_ptr_q];
    assign head_wdata = q_wdata_q[rd_ptr_q];
    assign head_word  = mem_q[head_addr];

    assign tc_rack    = pop && head_rnw;
    assign tc_wack    = pop && !head_rnw;
    assign tc_rdata   = tc_rack ? head_word : rdata_hold_q;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        timer_d      = timer_q;
        rdata_hold_d = rdata_hold_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        // Restart the head timer for the next entry after every pop.
        if (empty || pop) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 4'd1;
        end

        if (tc_rack) begin
            rdata_hold_d = head_word;
        end
    end

    // ---------------------------------------------------------------------
    // Control registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            timer_q      <= '0;
            rdata_hold_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            timer_q      <= timer_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    // ---------------------------------------------------------------------
    // Queue storage; write data is only captured for writes
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_bus) begin
        if (push) begin
            q_rnw_q[wr_ptr_q]  <= tc_rnw;
            q_addr_q[wr_ptr_q] <= tc_addr;
            if (!tc_rnw) begin
                q_wdata_q[wr_ptr_q] <= tc_wdata;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Word array: cleared by reset, so a write still queued when reset
    // arrives can never land.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (tc_wack) begin
            mem_q[head_addr] <= head_wdata;
        end
    end

endmodule

// File: tb/tb_tc_txn_buffer.sv
// ---------------------------------------------------------------------------
// tb_tc_txn_buffer
//
// Directed bench for tc_txn_buffer (TC_AWIDTH=8, TC_DWIDTH=8, DEPTH=4,
// SVC_LAT=2). Cycle numbers count rising edges of clk_bus; cycle n is the
// interval after the n-th edge. A monitor logs every rack/wack pulse with its
// cycle, which is later compared with hand-derived response cycles.
// ---------------------------------------------------------------------------
module tb_tc_txn_buffer;

    logic       clk_bus;
    logic       rst;
    logic       tc_req;
    logic       tc_rnw;
    logic [7:0] tc_addr;
    logic [7:0] tc_wdata;
    logic       tc_aack;
    logic       tc_rack;
    logic       tc_wack;
    logic [7:0] tc_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int         mon_cyc  [$];
    logic [1:0] mon_kind [$];
    logic [7:0] mon_data [$];

    tc_txn_buffer #(
        .TC_AWIDTH (8),
        .TC_DWIDTH (8),
        .DEPTH     (4),
        .SVC_LAT   (2)
    ) dut (
        .clk_bus  (clk_bus),
        .rst      (rst),
        .tc_req   (tc_req),
        .tc_rnw   (tc_rnw),
        .tc_addr  (tc_addr),
        .tc_wdata (tc_wdata),
        .tc_aack  (tc_aack),
        .tc_rack  (tc_rack),
        .tc_wack  (tc_wack),
        .tc_rdata (tc_rdata)
    );

    initial clk_bus = 1'b0;
    always #5 clk_bus = ~clk_bus;

    // Response monitor, sampled mid-cycle
    always @(negedge clk_bus) begin
        if (tc_rack || tc_wack) begin
            mon_cyc.push_back(cyc);
            mon_kind.push_back({tc_rack, tc_wack});
            mon_data.push_back(tc_rdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, got running, want finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_bus);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic rnw, input logic [7:0] a, input logic [7:0] d);
        tc_req   = 1'b1;
        tc_rnw   = rnw;
        tc_addr  = a;
        tc_wdata = d;
    endtask

    task automatic idle();
        tc_req   = 1'b0;
        tc_rnw   = 1'b0;
        tc_addr  = 8'h00;
        tc_wdata = 8'h00;
    endtask

    task automatic expect_rsp(input string tag, input int ecyc, input logic erd,
                              input logic [7:0] edata);
        int         c;
        logic [1:0] k;
        logic [7:0] d;
        if (mon_cyc.size() == 0) begin
            check({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            c = mon_cyc.pop_front();
            k = mon_kind.pop_front();
            d = mon_data.pop_front();
            $display("txn %s: cycle=%0d kind=%b data=0x%02h", tag, c, k, d);
            check({tag, "_cyc"}, c, ecyc);
            check({tag, "_kind"}, {30'd0, k}, erd ? 32'd2 : 32'd1);
            if (erd) begin
                check({tag, "_data"}, {24'd0, d}, {24'd0, edata});
            end
        end
    endtask

    task automatic check_no_more(input string tag);
        check(tag, mon_cyc.size(), 0);
        mon_cyc.delete();
        mon_kind.delete();
        mon_data.delete();
    endtask

    // Steady-state vectors: {rnw, addr, wdata, expected rdata}
    logic       s4_rnw  [11] = '{0, 0, 1, 0, 1, 1, 0, 1, 1, 0, 1};
    logic [7:0] s4_addr [11] = '{8'h40, 8'h41, 8'h40, 8'h42, 8'h41, 8'h42,
                                 8'h40, 8'h40, 8'h43, 8'h43, 8'h43};
    logic [7:0] s4_wd   [11] = '{8'h11, 8'h22, 8'h00, 8'h33, 8'h00, 8'h00,
                                 8'h44, 8'h00, 8'h00, 8'h55, 8'h00};
    logic [7:0] s4_exp  [11] = '{8'h00, 8'h00, 8'h11, 8'h00, 8'h22, 8'h33,
                                 8'h00, 8'h44, 8'h00, 8'h00, 8'h55};
    // aack expected in cycles t0..t0+9 while 8 reads are held back-to-back
    logic [9:0] s3_aack = 10'b1010111111;

    initial begin
        int t;
        int k;
        int off;

        // ---------------- reset ----------------
        rst = 1'b1;
        idle();
        tick();
        tick();
        check("rst_aack",  tc_aack,  1'b0);
        check("rst_rack",  tc_rack,  1'b0);
        check("rst_wack",  tc_wack,  1'b0);
        check("rst_rdata", tc_rdata, 8'h00);
        rst = 1'b0;
        #1;
        check("post_rst_aack", tc_aack, 1'b1);
        check_no_more("rst_no_rsp");

        // read of 0x10 after reset returns 0
        tick();
        drive(1'b1, 8'h10, 8'h00);
        t = cyc;
        check("s1_aack", tc_aack, 1'b1);
        tick();
        idle();
        repeat (4) tick();
        expect_rsp("s1_rd10", t + 2, 1'b1, 8'h00);
        check_no_more("s1_extra");

        // ---------------- write then dependent read ----------------
        drive(1'b0, 8'h3C, 8'hA5);
        t = cyc;
        check("s2_aack_w", tc_aack, 1'b1);
        tick();
        drive(1'b1, 8'h3C, 8'h00);
        check("s2_aack_r", tc_aack, 1'b1);
        tick();
        idle();
        repeat (5) tick();
        expect_rsp("s2_wr3c", t + 2, 1'b0, 8'h00);
        expect_rsp("s2_rd3c", t + 4, 1'b1, 8'hA5);
        check_no_more("s2_extra");

        // ---------------- speculative acknowledge ----------------
        for (int c = 0; c < 10; c++) begin
            idle();
            check("spec_aack", tc_aack, 1'b1);
            tick();
        end
        check_no_more("spec_no_rsp");
        drive(1'b1, 8'h3C, 8'h00);
        t = cyc;
        tick();
        idle();
        repeat (4) tick();
        expect_rsp("spec_rd3c", t + 2, 1'b1, 8'hA5);
        check_no_more("spec_extra");

        // ---------------- full queue: 8 reads held back-to-back ----------
        t = cyc;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            if (k < 8) begin
                drive(1'b1, (k % 2 == 0) ? 8'h3C : 8'h10, 8'h00);
            end else begin
                idle();
            end
            check("full_aack", tc_aack, s3_aack[c]);
            if (tc_aack && k < 8) begin
                k++;
            end
            tick();
        end
        idle();
        repeat (9) tick();
        for (int j = 0; j < 8; j++) begin
            expect_rsp("full_rd", t + 2 + 2 * j, 1'b1, (j % 2 == 0) ? 8'hA5 : 8'h00);
        end
        check_no_more("full_extra");

        // ---------------- steady state at occupancy 2, pointer wrap -------
        // Issue offsets 0,1,2,4,6,...: after the third accept every accept
        // coincides with a retire, so occupancy sits at 2.
        t = cyc;
        k = 0;
        for (int c = 0; c <= 20; c++) begin
            off = (k < 3) ? k : 2 * (k - 1);
            if (k < 11 && c == off) begin
                drive(s4_rnw[k], s4_addr[k], s4_wd[k]);
                check("ss_aack", tc_aack, 1'b1);
                k++;
            end else begin
                idle();
            end
            tick();
        end
        idle();
        repeat (3) tick();
        for (int j = 0; j < 11; j++) begin
            expect_rsp("ss_txn", t + 2 * j + 2, s4_rnw[j], s4_exp[j]);
        end
        check_no_more("ss_extra");
        check("ss_rdata_hold", tc_rdata, 8'h55);

        // ---------------- reset mid-operation ----------------
        t = cyc;
        drive(1'b1, 8'h3C, 8'h00);
        tick();
        drive(1'b0, 8'h05, 8'h77);
        tick();
        drive(1'b1, 8'h05, 8'h00);
        tick();
        drive(1'b1, 8'h10, 8'h00);
        tick();
        idle();
        // cycle t+4: write, two reads pending; write was due this cycle
        rst = 1'b1;
        #1;
        check("mid_rst_aack",  tc_aack,  1'b0);
        check("mid_rst_rack",  tc_rack,  1'b0);
        check("mid_rst_wack",  tc_wack,  1'b0);
        check("mid_rst_rdata", tc_rdata, 8'h00);
        tick();
        rst = 1'b0;
        #1;
        check("mid_post_aack", tc_aack, 1'b1);
        repeat (6) tick();
        expect_rsp("mid_pre_rd3c", t + 2, 1'b1, 8'hA5);
        check_no_more("mid_discard");

        drive(1'b1, 8'h05, 8'h00);
        t = cyc;
        tick();
        drive(1'b1, 8'h3C, 8'h00);
        tick();
        idle();
        repeat (4) tick();
        expect_rsp("mid_rd05", t + 2, 1'b1, 8'h00);
        expect_rsp("mid_rd3c", t + 4, 1'b1, 8'h00);
        check_no_more("mid_extra");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
